// File: rtl/mpwm_cfg_sequencer.sv
// Table-driven AXI4-Lite register writer: issues up to 8 {addr, data} writes in index order.
// Optional read-back verify of each write is compiled in with MPWM_SEQ_READBACK_EN.
module mpwm_cfg_sequencer #(
  parameter int ADDR_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              start,
  input  logic [3:0]        cnt,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              tbl_we,
  input  logic [2:0]        tbl_idx,
  input  logic [ADDR_W-1:0] tbl_addr,
  input  logic [31:0]       tbl_data,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [31:0]       m_wdata,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [31:0]       m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic [2:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // once raised, a valid stays high with stable addr/data until that edge.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_WB   = 3'd2,
`ifdef MPWM_SEQ_READBACK_EN
    S_RA   = 3'd3,
    S_RD   = 3'd4,
`endif
    S_DONE = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        idx;
  logic [3:0]        cnt_q;
  logic              err_q;
  logic              aw_done, w_done;
  logic [ADDR_W-1:0] tbl_a [8];
  logic [31:0]       tbl_d [8];

  logic              accept, advance, abort;
  logic              aw_hs, w_hs;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_data;

  assign cur_addr = tbl_a[idx[2:0]];
  assign cur_data = tbl_d[idx[2:0]];
  assign aw_hs    = m_awvalid & m_awready;
  assign w_hs     = m_wvalid & m_wready;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    advance   = 1'b0;
    abort     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (cnt == 4'd0) ? S_DONE : S_WR;
        end
      end
      S_WR: begin
        if ((aw_done | aw_hs) && (w_done | w_hs)) state_nxt = S_WB;
      end
      S_WB: begin
        if (m_bvalid) begin
          if (m_bresp != 2'b00) begin
            abort     = 1'b1;
            state_nxt = S_DONE;
          end else begin
`ifdef MPWM_SEQ_READBACK_EN
            state_nxt = S_RA;
`else
            advance   = 1'b1;
`endif
          end
        end
      end
`ifdef MPWM_SEQ_READBACK_EN
      S_RA: begin
        if (m_arready) state_nxt = S_RD;
      end
      S_RD: begin
        if (m_rvalid) begin
          if (m_rresp != 2'b00 || m_rdata != cur_data) begin
            abort     = 1'b1;
            state_nxt = S_DONE;
          end else begin
            advance   = 1'b1;
          end
        end
      end
`endif
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (advance) state_nxt = (idx + 4'd1 == cnt_q) ? S_DONE : S_WR;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      idx     <= 4'd0;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        tbl_a[i] <= '0;
        tbl_d[i] <= '0;
      end
    end else begin
      if (state == S_IDLE && tbl_we) begin
        tbl_a[tbl_idx] <= tbl_addr;
        tbl_d[tbl_idx] <= tbl_data;
      end
      if (accept) begin
        idx   <= 4'd0;
        cnt_q <= (cnt > 4'd8) ? 4'd8 : cnt;
        err_q <= 1'b0;
      end
      // AW and W complete independently; remember which side is finished.
      if (state == S_WR) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
        if (state_nxt == S_WB) begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end
      end
      if (abort)   err_q <= 1'b1;
      if (advance) idx   <= idx + 4'd1;
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign err       = err_q;
  assign m_awvalid = (state == S_WR) && !aw_done;
  assign m_wvalid  = (state == S_WR) && !w_done;
  assign m_awaddr  = m_awvalid ? cur_addr : '0;
  assign m_wdata   = m_wvalid ? cur_data : '0;
  assign m_bready  = (state == S_WB);
  assign dbg_state = state;

`ifdef MPWM_SEQ_READBACK_EN
  assign m_arvalid = (state == S_RA);
  assign m_araddr  = m_arvalid ? cur_addr : '0;
  assign m_rready  = (state == S_RD);
`else
  logic unused_rd;
  assign unused_rd = ^{m_arready, m_rvalid, m_rresp, m_rdata};
  assign m_arvalid = 1'b0;
  assign m_araddr  = '0;
  assign m_rready  = 1'b0;
`endif

endmodule

// File: tb/tb_mpwm_cfg_sequencer.sv
// Bench for mpwm_cfg_sequencer: directed runs against an AXI4-Lite slave model with a
// write scoreboard (expected {addr,data} queue) and a done/err queue checked by a monitor.
module tb_mpwm_cfg_sequencer;
  localparam int ADDR_W = 32;

  logic              ACLK = 1'b0;
  logic              ARESETN = 1'b0;
  logic              start = 1'b0;
  logic [3:0]        cnt = 4'd0;
  logic              busy, done, err;
  logic              tbl_we = 1'b0;
  logic [2:0]        tbl_idx = 3'd0;
  logic [ADDR_W-1:0] tbl_addr = '0;
  logic [31:0]       tbl_data = '0;
  logic [ADDR_W-1:0] m_awaddr, m_araddr;
  logic              m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [31:0]       m_wdata;
  logic              m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
  logic [1:0]        m_bresp, m_rresp;
  logic [31:0]       m_rdata;
  logic [2:0]        dbg_state;

  mpwm_cfg_sequencer #(.ADDR_W(ADDR_W)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .cnt(cnt),
    .busy(busy), .done(done), .err(err),
    .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .dbg_state(dbg_state)
  );

  // Clock
  always #5 ACLK = ~ACLK;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];
  logic        done_q[$];
  logic [31:0] mem [16];
  logic [31:0] tbl_a_m [8];
  logic [31:0] tbl_d_m [8];

  int   aw_delay = 0;
  int   err_entry = -1;
  logic corrupt_rd = 1'b0;
  int   b_count = 0;
  int   aw_cycles = 0;
  int   w_cycles = 0;
  int   ar_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave model plus monitor: negedge samples the handshakes that the next rising edge
  // completes; the slave then updates its outputs just after that edge.
  initial begin : slave
    logic hs_aw, hs_w, hs_b, hs_ar, hs_r;
    logic have_aw, have_w;
    logic [31:0] cap_addr, cap_data, ar_cap;
    logic prev_aw_wait, prev_w_wait;
    logic [31:0] prev_awaddr, prev_wdata;
    int aw_seen;
    have_aw = 0; have_w = 0; aw_seen = 0; prev_aw_wait = 0; prev_w_wait = 0;
    cap_addr = 0; cap_data = 0; ar_cap = 0; prev_awaddr = 0; prev_wdata = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
    for (int i = 0; i < 16; i++) mem[i] = 0;
    forever begin
      @(negedge ACLK);
      hs_aw = m_awvalid && m_awready;
      hs_w  = m_wvalid && m_wready;
      hs_b  = m_bvalid && m_bready;
      hs_ar = m_arvalid && m_arready;
      hs_r  = m_rvalid && m_rready;
      if (hs_aw) begin cap_addr = m_awaddr; have_aw = 1; end
      if (hs_w)  begin cap_data = m_wdata;  have_w = 1;  end
      if (hs_ar) ar_cap = m_araddr;
      if (m_awvalid) aw_cycles++;
      if (m_wvalid)  w_cycles++;
      if (m_arvalid) ar_total++;
      if (prev_aw_wait) chk("aw_stable", {31'd0, m_awvalid, m_awaddr}, {31'd0, 1'b1, prev_awaddr});
      if (prev_w_wait)  chk("w_stable",  {31'd0, m_wvalid, m_wdata},   {31'd0, 1'b1, prev_wdata});
      prev_aw_wait = ARESETN && m_awvalid && !m_awready;
      prev_w_wait  = ARESETN && m_wvalid && !m_wready;
      prev_awaddr  = m_awaddr;
      prev_wdata   = m_wdata;
      if (done) begin
        if (done_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
        else chk("done_busy_err", {62'd0, busy, err}, {62'd0, 1'b1, done_q.pop_front()});
      end
      @(posedge ACLK);
      #1;
      if (!ARESETN) begin
        have_aw = 0; have_w = 0; aw_seen = 0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
        continue;
      end
      if (hs_b) begin
        if (exp_q.size() == 0) chk("unexpected_write", {cap_addr, cap_data}, 64'd0);
        else chk("axi_write", {cap_addr, cap_data}, exp_q.pop_front());
        if (m_bresp == 2'b00) mem[cap_addr[5:2]] = cap_data;
        b_count++;
        m_bvalid = 0; have_aw = 0; have_w = 0;
      end else if (have_aw && have_w && !m_bvalid) begin
        m_bvalid = 1;
        m_bresp  = (b_count == err_entry) ? 2'b10 : 2'b00;
      end
      if (m_awvalid) begin
        m_awready = (aw_seen >= aw_delay);
        aw_seen++;
      end else begin
        m_awready = 0;
        aw_seen = 0;
      end
      m_wready = m_wvalid;
      if (hs_r) m_rvalid = 0;
      if (hs_ar) begin
        m_rvalid = 1;
        m_rresp  = 2'b00;
        m_rdata  = mem[ar_cap[5:2]];
        if (corrupt_rd && m_rdata == 32'h3) m_rdata = 32'h5;
      end
      m_arready = m_arvalid;
    end
  end

  task automatic load(input int i, input logic [31:0] a, input logic [31:0] d);
    @(posedge ACLK); #1;
    tbl_we = 1; tbl_idx = i[2:0]; tbl_addr = a; tbl_data = d;
    @(posedge ACLK); #1;
    tbl_we = 0;
    tbl_a_m[i] = a;
    tbl_d_m[i] = d;
  endtask

  task automatic kick(input logic [3:0] c);
    @(posedge ACLK); #1;
    start = 1; cnt = c;
    @(posedge ACLK); #1;
    start = 0;
    if (c != 0) chk("first_cycle", {60'd0, busy, m_awvalid, m_wvalid, done}, 64'b1110);
    else        chk("cnt0_cycle",  {60'd0, busy, m_awvalid, m_wvalid, done}, 64'b1001);
  endtask

  task automatic run_seq(input logic [3:0] c, input int n_exp, input logic exp_err);
    b_count = 0; aw_cycles = 0; w_cycles = 0;
    for (int i = 0; i < n_exp; i++) exp_q.push_back({tbl_a_m[i], tbl_d_m[i]});
    done_q.push_back(exp_err);
    kick(c);
    for (int k = 0; k < 300 && done_q.size() != 0; k++) @(posedge ACLK);
    chk("done_timeout", done_q.size(), 0);
    done_q.delete();
    @(posedge ACLK); #1;
    chk("back_idle", {63'd0, busy}, 64'd0);
    chk("writes_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin : main
    for (int i = 0; i < 8; i++) begin tbl_a_m[i] = 0; tbl_d_m[i] = 0; end
    ARESETN = 0;
    repeat (3) @(posedge ACLK);
    #1;
    chk("reset_ctrl", {56'd0, busy, done, err, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 64'd0);
    chk("reset_addr_data", {m_awaddr, m_wdata}, 64'd0);
    ARESETN = 1;

    // Four ordered writes, zero-wait slave
    for (int i = 0; i < 4; i++) load(i, 32'(i * 4), 32'(i + 1));
    run_seq(4, 4, 1'b0);
    chk("basic_b_count", b_count, 4);
    for (int i = 0; i < 4; i++) chk("basic_mem", mem[i], 64'(i + 1));

    // AW held by slow awready, W completes at once
    aw_delay = 2;
    run_seq(2, 2, 1'b0);
    aw_delay = 0;
    chk("slow_aw_cycles", aw_cycles, 6);
    chk("slow_w_cycles", w_cycles, 2);
    chk("slow_b_count", b_count, 2);

    // SLVERR on second entry aborts; third entry never issued; next start clears err
    load(0, 32'h10, 32'hA);
    load(1, 32'h14, 32'hB);
    load(2, 32'h18, 32'hC);
    err_entry = 1;
    run_seq(3, 2, 1'b1);
    err_entry = -1;
    chk("slverr_b_count", b_count, 2);
    chk("slverr_aw_cycles", aw_cycles, 2);
    chk("slverr_err_sticky", {63'd0, err}, 64'd1);
    chk("slverr_no_third", mem[6], 64'd0);
    run_seq(0, 0, 1'b0);
    chk("cnt0_no_valid", aw_cycles + w_cycles, 0);
    chk("err_cleared", {63'd0, err}, 64'd0);

    // cnt=15 clamps to 8 writes
    for (int i = 0; i < 8; i++) load(i, 32'h20 + 32'(i * 4), 32'h100 + 32'(i));
    run_seq(15, 8, 1'b0);
    chk("clamp_b_count", b_count, 8);
    chk("clamp_mem_last", mem[15], 64'h107);

    // Table write while busy is ignored
    fork
      run_seq(1, 1, 1'b0);
      begin
        repeat (2) @(posedge ACLK);
        #1;
        tbl_we = 1; tbl_idx = 3'd0; tbl_addr = 32'h3C; tbl_data = 32'hDEAD;
        @(posedge ACLK); #1;
        tbl_we = 0;
      end
    join
    run_seq(1, 1, 1'b0);

    // Reset during WB of entry 2: no done, outputs cleared, table cleared
    b_count = 0;
    for (int i = 0; i < 2; i++) exp_q.push_back({tbl_a_m[i], tbl_d_m[i]});
    kick(4'd4);
    for (int k = 0; k < 100; k++) begin
      @(negedge ACLK);
      if (m_bready && b_count == 2) break;
    end
    chk("reached_wb2", {62'd0, m_bready, (b_count == 2)}, 64'b11);
    #2 ARESETN = 0;
    #1;
    chk("midrst_ctrl", {56'd0, busy, done, err, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 64'd0);
    chk("midrst_addr_data", {m_awaddr, m_wdata}, 64'd0);
    repeat (3) @(posedge ACLK);
    #1 ARESETN = 1;
    chk("midrst_writes", exp_q.size(), 0);
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin tbl_a_m[i] = 0; tbl_d_m[i] = 0; end
    run_seq(1, 1, 1'b0);
    for (int i = 0; i < 4; i++) load(i, 32'(i * 4), 32'(i + 1));
    run_seq(4, 4, 1'b0);
    chk("restart_b_count", b_count, 4);

`ifdef MPWM_SEQ_READBACK_EN
    // Read-back mismatch on the entry holding 0x3 aborts after that entry
    corrupt_rd = 1'b1;
    run_seq(4, 3, 1'b1);
    corrupt_rd = 1'b0;
    chk("rb_b_count", b_count, 3);
    chk("rb_err", {63'd0, err}, 64'd1);
`else
    chk("no_read_traffic", ar_total, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
